// File: rtl/motoro3_pkg.sv
// Shared definitions for the 3-phase six-step motor drive.
// Holds the bus widths, the parameter defaults and the commutation table
// ({hi[2:0], lo[2:0]} per step, bit order {C,B,A}).
package motoro3_pkg;

   localparam int unsigned STEP_W          = 3;
   localparam int unsigned NUM_STEPS       = 6;
   localparam int unsigned RELOAD_W        = 25;
   localparam int unsigned LEN_W           = 12;
   localparam int unsigned PWR_W           = 8;
   localparam int unsigned PROD_W          = LEN_W + PWR_W;
   localparam int unsigned RELOAD_MIN      = 2;
   localparam int unsigned PWM_LEN_MIN_DEF = 64;
   localparam int unsigned DEAD_CLKS_DEF   = 16;

   typedef struct packed {
      logic [2:0] hi;
      logic [2:0] lo;
   } comm_t;

   // Step n: high-side phase / low-side phase
   localparam comm_t COMM_S0 = '{hi: 3'b001, lo: 3'b010}; // A / B
   localparam comm_t COMM_S1 = '{hi: 3'b001, lo: 3'b100}; // A / C
   localparam comm_t COMM_S2 = '{hi: 3'b010, lo: 3'b100}; // B / C
   localparam comm_t COMM_S3 = '{hi: 3'b010, lo: 3'b001}; // B / A
   localparam comm_t COMM_S4 = '{hi: 3'b100, lo: 3'b001}; // C / A
   localparam comm_t COMM_S5 = '{hi: 3'b100, lo: 3'b010}; // C / B

   // Unused indices 6/7 map to all-off so a corrupted index can never short a leg
   function automatic comm_t comm_lookup(input logic [STEP_W-1:0] idx);
      comm_t c;
      c = '0;
      case (idx)
         3'd0:    c = COMM_S0;
         3'd1:    c = COMM_S1;
         3'd2:    c = COMM_S2;
         3'd3:    c = COMM_S3;
         3'd4:    c = COMM_S4;
         3'd5:    c = COMM_S5;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/motoro3_duty_calc.sv
// Two-stage duty pipeline: stage 1 registers the effective period and the
// raw duty (len_eff * power) >> 8; stage 2 registers the min-pulse-clamped duty.
// Ports: clk, nRst, len_want/power/min_mask (live config),
//        len_eff_q/duty_q (registered period and clamped duty).
module motoro3_duty_calc
   import motoro3_pkg::*;
#(
   parameter int unsigned PWM_LEN_MIN = PWM_LEN_MIN_DEF
)(
   input  logic             clk,
   input  logic             nRst,
   input  logic [LEN_W-1:0] len_want,
   input  logic [PWR_W-1:0] power,
   input  logic [LEN_W-1:0] min_mask,
   output logic [LEN_W-1:0] len_eff_q,
   output logic [LEN_W-1:0] duty_q
);

   logic [LEN_W-1:0] len_eff_c;
   logic [LEN_W-1:0] raw_c;
   logic [LEN_W-1:0] duty_c;
   logic [LEN_W-1:0] len_s1;
   logic [LEN_W-1:0] raw_s1;
   logic [LEN_W-1:0] mask_s1;

   // Stage 1 combinational: period floor and scaled duty
   always_comb begin
      len_eff_c = (len_want < LEN_W'(PWM_LEN_MIN)) ? LEN_W'(PWM_LEN_MIN) : len_want;
      raw_c     = LEN_W'((PROD_W'(len_eff_c) * PROD_W'(power)) >> PWR_W);
   end

   // Stage 2 combinational: too-short pulses drop to 0, too-short gaps go full on
   always_comb begin
      duty_c = raw_s1;
      if (raw_s1 < mask_s1)
         duty_c = '0;
      else if (len_s1 <= mask_s1)
         duty_c = '0;
      else if (raw_s1 >= len_s1 - mask_s1)
         duty_c = len_s1;
   end

   // Mask travels with its operands so both stages see one consistent config
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         len_s1    <= '0;
         raw_s1    <= '0;
         mask_s1   <= '0;
         len_eff_q <= '0;
         duty_q    <= '0;
      end else begin
         len_s1    <= len_eff_c;
         raw_s1    <= raw_c;
         mask_s1   <= min_mask;
         len_eff_q <= len_s1;
         duty_q    <= duty_c;
      end
   end

endmodule

// File: rtl/motoro3_drive.sv
// Six-step commutation and PWM gate generator for the 3-phase driver.
// Ports: clk, nRst (async active-low), m3_enable (run request),
//        m3r_step_cnt_reload1 / m3r_power_percent / m3r_pwmLenWant / m3r_pwmMinMask (config),
//        m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo (all registered).
module motoro3_drive
   import motoro3_pkg::*;
#(
   parameter int unsigned DEAD_CLKS   = DEAD_CLKS_DEF,
   parameter int unsigned PWM_LEN_MIN = PWM_LEN_MIN_DEF
)(
   input  logic                clk,
   input  logic                nRst,
   input  logic                m3_enable,
   input  logic [RELOAD_W-1:0] m3r_step_cnt_reload1,
   input  logic [PWR_W-1:0]    m3r_power_percent,
   input  logic [LEN_W-1:0]    m3r_pwmLenWant,
   input  logic [LEN_W-1:0]    m3r_pwmMinMask,
   output logic [STEP_W-1:0]   m3_step_idx,
   output logic                m3_step_tick,
   output logic                m3_pwm_on,
   output logic [2:0]          m3_gate_hi,
   output logic [2:0]          m3_gate_lo
);

   localparam int unsigned DEAD_W = $clog2(DEAD_CLKS + 1);

   logic                en_q;
   logic [RELOAD_W-1:0] step_cnt;
   logic [DEAD_W-1:0]   dead_cnt;
   logic [LEN_W-1:0]    pwm_cnt;
   logic [LEN_W-1:0]    len_act;
   logic [LEN_W-1:0]    duty_act;
   logic [LEN_W-1:0]    len_pipe;
   logic [LEN_W-1:0]    duty_pipe;

   logic [RELOAD_W-1:0] reload_eff_c;
   logic                pwm_hit_c;
   logic                gate_ok_c;
   comm_t               comm_c;

   motoro3_duty_calc #(
      .PWM_LEN_MIN (PWM_LEN_MIN)
   ) u_duty (
      .clk       (clk),
      .nRst      (nRst),
      .len_want  (m3r_pwmLenWant),
      .power     (m3r_power_percent),
      .min_mask  (m3r_pwmMinMask),
      .len_eff_q (len_pipe),
      .duty_q    (duty_pipe)
   );

   // Derived terms: step length floor, PWM on-phase, gate permission, table row
   always_comb begin
      reload_eff_c = (m3r_step_cnt_reload1 < RELOAD_W'(RELOAD_MIN)) ?
                     RELOAD_W'(RELOAD_MIN) : m3r_step_cnt_reload1;
      pwm_hit_c    = (pwm_cnt < duty_act);
      gate_ok_c    = m3_enable & en_q & (dead_cnt == '0);
      comm_c       = comm_lookup(m3_step_idx);
   end

   // Enable edge detect; en_q low while enabled marks the counter-load cycle
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) en_q <= 1'b0;
      else       en_q <= m3_enable;
   end

   // Step down-counter, commutation index and dead-time counter
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         step_cnt     <= '0;
         dead_cnt     <= '0;
         m3_step_idx  <= '0;
         m3_step_tick <= 1'b0;
      end else begin
         m3_step_tick <= 1'b0;
         if (!m3_enable) begin
            step_cnt <= '0;
            dead_cnt <= '0;
         end else if (!en_q) begin
            step_cnt <= reload_eff_c;
            dead_cnt <= '0;
         end else if (step_cnt == RELOAD_W'(1)) begin
            step_cnt     <= reload_eff_c;
            dead_cnt     <= DEAD_W'(DEAD_CLKS);
            m3_step_tick <= 1'b1;
            m3_step_idx  <= (m3_step_idx == STEP_W'(NUM_STEPS - 1)) ?
                            '0 : m3_step_idx + STEP_W'(1);
         end else begin
            if (step_cnt != '0) step_cnt <= step_cnt - RELOAD_W'(1);
            if (dead_cnt != '0) dead_cnt <= dead_cnt - DEAD_W'(1);
         end
      end
   end

   // Free-running PWM counter; period/duty only change at a wrap or at start
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         pwm_cnt  <= '0;
         len_act  <= '0;
         duty_act <= '0;
      end else if (!m3_enable) begin
         pwm_cnt  <= '0;
         len_act  <= '0;
         duty_act <= '0;
      end else if (!en_q || (pwm_cnt == LEN_W'(len_act - LEN_W'(1)))) begin
         pwm_cnt  <= '0;
         len_act  <= len_pipe;
         duty_act <= duty_pipe;
      end else begin
         pwm_cnt  <= pwm_cnt + LEN_W'(1);
      end
   end

   // Registered gate drive; table rows never share a phase between hi and lo
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         m3_pwm_on  <= 1'b0;
         m3_gate_hi <= '0;
         m3_gate_lo <= '0;
      end else begin
         m3_pwm_on  <= m3_enable & pwm_hit_c;
         m3_gate_hi <= gate_ok_c ? (comm_c.hi & {3{pwm_hit_c}}) : 3'b000;
         m3_gate_lo <= gate_ok_c ? comm_c.lo : 3'b000;
      end
   end

endmodule

// File: tb/tb_motoro3_drive.sv
// Self-checking bench for motoro3_drive: randomized and directed scenarios
// compared every cycle against a behavioural model of the drive.
`timescale 1ns/1ps
module tb_motoro3_drive;

   logic        clk = 1'b0;
   logic        nRst;
   logic        en;
   logic [24:0] reload;
   logic [7:0]  power;
   logic [11:0] lenw;
   logic [11:0] mask;
   logic [2:0]  m3_step_idx;
   logic        m3_step_tick;
   logic        m3_pwm_on;
   logic [2:0]  m3_gate_hi;
   logic [2:0]  m3_gate_lo;

   int errors = 0;
   int checks = 0;

   // Model state (as of the most recent clock edge)
   int m_run, m_age, m_idx, m_last, m_pos, m_len, m_duty;
   int h1l, h1d, h2l, h2d;
   logic [2:0] e_idx;
   logic       e_tick, e_pwm;
   logic [2:0] e_hi, e_lo;
   logic [10:0] got, exp_v;

   int hi_ph [6] = '{0, 0, 1, 1, 2, 2};
   int lo_ph [6] = '{1, 2, 2, 0, 0, 1};

   always #50 clk = ~clk;

   motoro3_drive dut (
      .clk                  (clk),
      .nRst                 (nRst),
      .m3_enable            (en),
      .m3r_step_cnt_reload1 (reload),
      .m3r_power_percent    (power),
      .m3r_pwmLenWant       (lenw),
      .m3r_pwmMinMask       (mask),
      .m3_step_idx          (m3_step_idx),
      .m3_step_tick         (m3_step_tick),
      .m3_pwm_on            (m3_pwm_on),
      .m3_gate_hi           (m3_gate_hi),
      .m3_gate_lo           (m3_gate_lo)
   );

   function automatic int eff_len(input int lw);
      return (lw < 64) ? 64 : lw;
   endfunction

   function automatic int eff_duty(input int lw, input int pw, input int mk);
      int le, raw;
      le  = eff_len(lw);
      raw = (le * pw) / 256;
      if (raw < mk) return 0;
      if (le <= mk) return 0;
      if (raw >= le - mk) return le;
      return raw;
   endfunction

   task automatic model_reset();
      m_run = 0; m_age = 0; m_idx = 0; m_last = -1000;
      m_pos = 0; m_len = 0; m_duty = 0;
      h1l = 0; h1d = 0; h2l = 0; h2d = 0;
      e_idx = 0; e_tick = 0; e_pwm = 0; e_hi = 0; e_lo = 0;
   endtask

   // Advance model by one edge using the inputs now applied, then wait for it
   task automatic clk_step();
      int   r;
      logic dead;
      r      = (int'(reload) < 2) ? 2 : int'(reload);
      e_tick = 1'b0;
      if (en && m_run != 0) begin
         dead  = (m_age - m_last) < 16;
         e_pwm = (m_pos < m_duty);
         e_hi  = dead ? 3'b000 : (3'(1 << hi_ph[m_idx]) & {3{e_pwm}});
         e_lo  = dead ? 3'b000 : 3'(1 << lo_ph[m_idx]);
      end else begin
         e_pwm = 1'b0; e_hi = 3'b000; e_lo = 3'b000;
      end
      if (!en) begin
         m_run = 0; m_age = 0; m_pos = 0; m_len = 0; m_duty = 0; m_last = -1000;
      end else if (m_run == 0) begin
         m_run = 1; m_age = 0; m_pos = 0; m_len = h2l; m_duty = h2d; m_last = -1000;
      end else begin
         m_age++;
         if (m_age % r == 0) begin
            e_tick = 1'b1;
            m_idx  = (m_idx + 1) % 6;
            m_last = m_age;
         end
         m_pos++;
         if (m_pos == m_len) begin
            m_pos = 0; m_len = h2l; m_duty = h2d;
         end
      end
      e_idx = 3'(m_idx);
      h2l = h1l; h2d = h1d;
      h1l = eff_len(int'(lenw));
      h1d = eff_duty(int'(lenw), int'(power), int'(mask));
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input int r, input int p, input int l, input int m);
      en = 1'b0;
      reload = 25'(r); power = 8'(p); lenw = 12'(l); mask = 12'(m);
      repeat (3) clk_step();
   endtask

   task automatic test_reset();
      #120;
      checks++;
      got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
      if (got !== 11'd0) begin
         errors++; $display("FAIL reset_outputs got=%h exp=%h", got, 11'd0);
      end
      @(negedge clk) nRst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, got, exp_v); end
      end
   endtask

   task automatic test_basic();
      int ticks, idx0;
      configure(20, 8'h10, 512, 32);
      idx0 = m_idx; ticks = 0;
      en = 1'b1;
      for (int i = 0; i < 1100; i++) begin
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL basic cyc=%0d got=%h exp=%h", i, got, exp_v); end
         if (m3_step_tick === 1'b1) begin
            ticks++;
            checks++;
            if (m3_step_idx !== 3'((idx0 + ticks) % 6)) begin
               errors++; $display("FAIL basic_idx got=%0d exp=%0d", m3_step_idx, (idx0 + ticks) % 6);
            end
         end
      end
      checks++;
      if (ticks != 54) begin errors++; $display("FAIL basic_tick_count got=%0d exp=54", ticks); end
   endtask

   task automatic test_min_mask();
      configure(20, 8'h0F, 512, 32);
      en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL min_mask cyc=%0d got=%h exp=%h", i, got, exp_v); end
         checks++;
         if (m3_pwm_on !== 1'b0 || m3_gate_hi !== 3'b000) begin
            errors++; $display("FAIL min_mask_hi cyc=%0d pwm=%b hi=%b exp=0", i, m3_pwm_on, m3_gate_hi);
         end
      end
   endtask

   task automatic test_full_on();
      configure(20, 8'hFF, 512, 32);
      en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL full_on cyc=%0d got=%h exp=%h", i, got, exp_v); end
         if (i >= 1) begin
            checks++;
            if (m3_pwm_on !== 1'b1) begin errors++; $display("FAIL full_on_pwm cyc=%0d got=%b exp=1", i, m3_pwm_on); end
         end
      end
   endtask

   task automatic test_len_change();
      int on1, on2;
      configure(20, 8'h10, 512, 32);
      en = 1'b1; on1 = 0; on2 = 0;
      clk_step();
      for (int i = 1; i <= 768; i++) begin
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL len_change cyc=%0d got=%h exp=%h", i, got, exp_v); end
         if (i <= 512) on1 += int'(m3_pwm_on === 1'b1);
         else          on2 += int'(m3_pwm_on === 1'b1);
         if (i == 100) lenw = 12'd256;
      end
      checks++;
      if (on1 != 32) begin errors++; $display("FAIL len_change_first got=%0d exp=32", on1); end
      checks++;
      if (on2 != 0) begin errors++; $display("FAIL len_change_second got=%0d exp=0", on2); end
   endtask

   task automatic test_fast_step();
      configure(0, 8'h80, 10, 8);
      en = 1'b1;
      clk_step();
      for (int i = 1; i < 300; i++) begin
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL fast_step cyc=%0d got=%h exp=%h", i, got, exp_v); end
         checks++;
         if ((m3_gate_hi & m3_gate_lo) !== 3'b000) begin
            errors++; $display("FAIL shoot_through cyc=%0d hi=%b lo=%b", i, m3_gate_hi, m3_gate_lo);
         end
         checks++;
         if (m3_pwm_on !== (((i - 1) % 64) < 32)) begin
            errors++; $display("FAIL fast_pwm64 cyc=%0d got=%b exp=%b", i, m3_pwm_on, (((i - 1) % 64) < 32));
         end
         if (i >= 3) begin
            checks++;
            if ({m3_gate_hi, m3_gate_lo} !== 6'b0) begin
               errors++; $display("FAIL fast_dead cyc=%0d got=%b exp=0", i, {m3_gate_hi, m3_gate_lo});
            end
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [2:0] held;
      int k;
      configure(20, 8'h10, 512, 32);
      en = 1'b1;
      for (int i = 0; i < 30; i++) clk_step();
      held = e_idx;
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {held, 1'b0, 1'b0, 3'b000, 3'b000};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL en_drop cyc=%0d got=%h exp=%h", i, got, exp_v); end
      end
      en = 1'b1;
      for (k = 0; k < 100; k++) begin
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL re_enable cyc=%0d got=%h exp=%h", k, got, exp_v); end
         if (m3_step_tick === 1'b1) break;
      end
      checks++;
      if (k != 20) begin errors++; $display("FAIL re_enable_first_tick got=%0d exp=20", k); end
   endtask

   task automatic test_reset_mid();
      configure(20, 8'h10, 512, 32);
      en = 1'b1;
      for (int i = 0; i < 30; i++) clk_step();
      #20 nRst = 1'b0;
      #1;
      got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
      checks++;
      if (got !== 11'd0) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, 11'd0); end
      model_reset();
      en = 1'b0;
      @(negedge clk) nRst = 1'b1;
      for (int i = 0; i < 63; i++) begin
         if (i == 3) en = 1'b1;
         clk_step();
         got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
         exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, got, exp_v); end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         configure(int'($urandom_range(0, 40)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 300)), int'($urandom_range(0, 80)));
         en = 1'b1;
         for (int i = 0; i < 400; i++) begin
            if (i == 200) power = 8'($urandom_range(0, 255));
            clk_step();
            got = {m3_step_idx, m3_step_tick, m3_pwm_on, m3_gate_hi, m3_gate_lo};
            exp_v = {e_idx, e_tick, e_pwm, e_hi, e_lo};
            checks++;
            if (got !== exp_v) begin
               errors++; $display("FAIL random run=%0d cyc=%0d got=%h exp=%h", n, i, got, exp_v);
            end
         end
      end
   endtask

   initial begin
      nRst = 1'b0; en = 1'b0;
      reload = '0; power = '0; lenw = '0; mask = '0;
      model_reset();
      test_reset();
      test_basic();
      test_min_mask();
      test_full_on();
      test_len_change();
      test_fast_step();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/motoro3_drive.md
# motoro3_drive

Six-step commutation and PWM gate generator for the 3-phase motor driver. It consumes the runtime configuration words `m3r_step_cnt_reload1`, `m3r_power_percent`, `m3r_pwmLenWant` and `m3r_pwmMinMask` from the register block. It produces registered high-side and low-side gate enables for phases A/B/C, with glitch-free configuration updates, minimum-pulse masking and dead time at commutation. It sits between the register block and the MOSFET driver pins and runs on the 10 MHz system clock.

## Interface
Parameters:
- `DEAD_CLKS`, 16: clocks all gates are forced off after each commutation (1.6 µs).
- `PWM_LEN_MIN`, 64: floor applied to the PWM period length.

Ports (one clock, `clk`; reset `nRst` is asynchronous and active-low):
- `clk`  in  1  10 MHz system clock.
- `nRst`  in  1  async active-low reset.
- `m3_enable`  in  1  run request; low = all gates off, counters held.
- `m3r_step_cnt_reload1`  in  25  clocks per commutation step.
- `m3r_power_percent`  in  8  duty fraction, in units of 1/256 of the period.
- `m3r_pwmLenWant`  in  12  PWM period in clocks.
- `m3r_pwmMinMask`  in  12  minimum on/off pulse width in clocks.
- `m3_step_idx`  out  3  current commutation step, 0..5.
- `m3_step_tick`  out  1  one-cycle pulse on each step advance.
- `m3_pwm_on`  out  1  raw PWM on-phase, before commutation gating.
- `m3_gate_hi`  out  3  high-side enables {C,B,A}.
- `m3_gate_lo`  out  3  low-side enables {C,B,A}.

## Operation
- Reset: all outputs 0; `m3_step_idx`=0; all counters 0.
- Effective values:
  - `reload_eff` = max(reload, 2).
  - `len_eff` = max(pwmLenWant, PWM_LEN_MIN).
- Duty pipeline:
  - Stage 1 registers `duty_raw` = (len_eff × power) >> 8 from the live inputs (20-bit product, upper 12 bits kept).
  - Stage 2 clamps: if `duty_raw` < minMask then 0; else if `duty_raw` ≥ len_eff − minMask then len_eff (full on).
  - The low check is applied first.
  - If len_eff ≤ minMask, the result is 0.
- Active set: `len_act` and `duty_act` load from `len_eff` and the clamped duty only when the PWM counter wraps, or on the first cycle after enable rises. A mid-period change never alters the current period.
- PWM counter: 12-bit, counts 0..`len_act`−1 and wraps to 0. `m3_pwm_on` = (cnt < `duty_act`).
- Step counter: 25-bit down counter, loaded with `reload_eff` at enable rise and at each tick. On the clock it equals 1:
  - `m3_step_tick` pulses.
  - `m3_step_idx` increments mod 6 (5 → 0).
- Commutation (hi/lo):
  - step 0: A/B
  - step 1: A/C
  - step 2: B/C
  - step 3: B/A
  - step 4: C/A
  - step 5: C/B
- The high side is ANDed with `m3_pwm_on`. The low side is on for the whole step.
- Dead time: a counter loaded with `DEAD_CLKS` on each `m3_step_tick` forces both gate vectors to 0 while it is nonzero.
- Invariant: `m3_gate_hi` & `m3_gate_lo` == 0 always. The same phase is never hi and lo together.
- `m3_enable` low:
  - Gates are 0 and the counters are cleared.
  - `m3_step_idx` retains its value.
  - Dead time is cleared.

## Timing
- Gate outputs are registered: they change 1 clock after the internal state that causes them.
- Enable rise at cycle T:
  - Counters load at T+1.
  - The first tick comes `reload_eff` clocks later.
  - Gates obey the dead-time rule from T+1 (dead time is not started by enable).
- Duty latency: an input change reaches `duty_act` at the first PWM wrap at least 2 clocks later.
- Step period is exactly `reload_eff` clocks. The tick and the index change occur in the same cycle.
- Tick coinciding with a PWM wrap: both take effect; the PWM counter is free-running and is not reset by commutation.
- Async `nRst` assertion at any time: outputs go to 0 immediately. Release is synchronised by the clock.

## Structure
- Shared package `motoro3_pkg`:
  - the commutation table constants (6 × {hi[2:0], lo[2:0]});
  - the `PWM_LEN_MIN` and `DEAD_CLKS` defaults;
  - the step-index width.
- Sub-module `motoro3_duty_calc` holds the two-stage multiply/clamp pipeline. The top level holds the counters, commutation and gating.

## Test plan
- Reload=20, len=512, power=0x10, mask=32, enable=1 → a tick every 20 clocks; idx 0,1,2,3,4,5,0. In each 512-clock period the hi gate is on for 32 clocks.
- Power=0x0F (duty 30 < 32) → `m3_pwm_on` never asserts and `m3_gate_hi` stays 0; `m3_gate_lo` follows the table.
- Power=0xFF, len=512 (duty 510 ≥ 480) → `m3_pwm_on` constant 1 and the hi gate is continuously on outside dead time.
- pwmLenWant changed 512→256 at cnt=100 → the current period still lasts 512 clocks; the next period is 256 clocks with duty 16 (then masked to 0 with mask 32).
- Reload=0 and pwmLenWant=10 → the tick period is 2 clocks and the PWM period is 64 clocks. After every tick the gates are 0 for 16 clocks, and hi&lo stays 0 throughout.
- nRst pulsed mid-step, and separately enable dropped mid-step:
  - nRst → all outputs 0 and idx=0.
  - enable drop → gates 0 and idx held; on re-enable the first tick comes after a full `reload_eff`.
